// File: rtl/wb_retire_stage.sv
// wb_retire_stage
//  In-order retire buffer that sits between the MEM stage and the shared
//  register-file write port. Results from MEM are queued in a DEPTH-entry
//  circular buffer. One entry retires per cycle when the RF port grants;
//  entries that do not write the RF retire without waiting for a grant.
//  Decode gets a youngest-first bypass lookup over every pending entry.
//
//  Optional feature macro: WB_TRACE_EN
//   defined     -> a PC is stored per entry and the debug_wb_* trace outputs
//                  report each retirement
//   not defined -> PC bits of the incoming bus are ignored and every
//                  debug_wb_* output is tied to zero
module wb_retire_stage #(
   parameter int DATA_WD = 32,
   parameter int ADDR_WD = 5,
   parameter int PC_WD   = 32,
   parameter int DEPTH   = 2
) (
   input  logic                                 clk,
   input  logic                                 reset,

   input  logic                                 ms_to_ws_valid,
   input  logic [1+ADDR_WD+DATA_WD+PC_WD-1:0]   ms_to_ws_bus,
   output logic                                 ws_allowin,

   input  logic                                 flush,

   input  logic                                 rf_wr_ready,
   output logic [1+ADDR_WD+DATA_WD-1:0]         ws_to_rf_bus,

   output logic                                 ws_to_ds_valid,
   output logic [$clog2(DEPTH+1)-1:0]           ws_pending_cnt,

   input  logic [ADDR_WD-1:0]                   ds_rs1,
   input  logic [ADDR_WD-1:0]                   ds_rs2,
   output logic                                 ws_rs1_hit,
   output logic                                 ws_rs2_hit,
   output logic [DATA_WD-1:0]                   ws_rs1_data,
   output logic [DATA_WD-1:0]                   ws_rs2_data,

   output logic [PC_WD-1:0]                     debug_wb_pc,
   output logic [3:0]                           debug_wb_rf_we,
   output logic [ADDR_WD-1:0]                   debug_wb_rf_wnum,
   output logic [DATA_WD-1:0]                   debug_wb_rf_wdata
);

   localparam int PTR_WD = $clog2(DEPTH);
   localparam int CNT_WD = $clog2(DEPTH + 1);
   localparam int BUS_WD = 1 + ADDR_WD + DATA_WD + PC_WD;
   localparam logic [CNT_WD-1:0] FULL_CNT = CNT_WD'(DEPTH);

   // Buffer bookkeeping: pointers wrap for free because DEPTH is a power of 2
   logic [PTR_WD-1:0]  wptr;
   logic [PTR_WD-1:0]  rptr;
   logic [CNT_WD-1:0]  count;

   // Per-entry storage
   logic               ent_we   [DEPTH];
   logic [ADDR_WD-1:0] ent_dest [DEPTH];
   logic [DATA_WD-1:0] ent_data [DEPTH];

   // Fields of the incoming MEM result
   logic               in_we;
   logic [ADDR_WD-1:0] in_dest;
   logic [DATA_WD-1:0] in_data;

   assign in_we   = ms_to_ws_bus[BUS_WD-1];
   assign in_dest = ms_to_ws_bus[PC_WD+DATA_WD +: ADDR_WD];
   assign in_data = ms_to_ws_bus[PC_WD +: DATA_WD];

   // Head of the buffer (oldest pending entry); fields read as zero when empty
   logic               head_valid;
   logic               head_we;
   logic [ADDR_WD-1:0] head_dest;
   logic [DATA_WD-1:0] head_data;

   assign head_valid = (count != '0);
   assign head_we    = head_valid & ent_we[rptr];
   assign head_dest  = head_valid ? ent_dest[rptr] : '0;
   assign head_data  = head_valid ? ent_data[rptr] : '0;

   // Handshakes. allowin depends only on occupancy so that a stalled RF port
   // never feeds back combinationally into MEM.
   logic push;
   logic pop;
   logic rf_we;

   assign ws_allowin = (count != FULL_CNT);
   assign push       = ms_to_ws_valid & ws_allowin & ~flush;
   assign pop        = head_valid & (rf_wr_ready | ~head_we) & ~flush;
   assign rf_we      = head_we & ~flush;

   assign ws_to_rf_bus   = {rf_we, head_dest, head_data};
   assign ws_to_ds_valid = head_valid;
   assign ws_pending_cnt = count;

   // Pointer and occupancy update; flush empties the buffer just like reset
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + PTR_WD'(1);
         end
         if (pop) begin
            rptr <= rptr + PTR_WD'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_WD'(1);
            2'b01:   count <= count - CNT_WD'(1);
            default: count <= count;
         endcase
      end
   end

   // Capture an accepted MEM result into the slot at the write pointer
   always_ff @(posedge clk) begin
      if (push) begin
         ent_we[wptr]   <= in_we;
         ent_dest[wptr] <= in_dest;
         ent_data[wptr] <= in_data;
      end
   end

   // Bypass lookup: walk pending entries oldest to youngest so that a younger
   // match overwrites an older one, leaving the youngest producer as result
   logic [PTR_WD-1:0] scan_idx;

   always_comb begin
      ws_rs1_hit  = 1'b0;
      ws_rs1_data = '0;
      ws_rs2_hit  = 1'b0;
      ws_rs2_data = '0;
      scan_idx    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = rptr + PTR_WD'(i);
         if ((CNT_WD'(i) < count) && ent_we[scan_idx]) begin
            if ((ds_rs1 != '0) && (ent_dest[scan_idx] == ds_rs1)) begin
               ws_rs1_hit  = 1'b1;
               ws_rs1_data = ent_data[scan_idx];
            end
            if ((ds_rs2 != '0) && (ent_dest[scan_idx] == ds_rs2)) begin
               ws_rs2_hit  = 1'b1;
               ws_rs2_data = ent_data[scan_idx];
            end
         end
      end
   end

`ifdef WB_TRACE_EN
   logic [PC_WD-1:0] ent_pc [DEPTH];
   logic [PC_WD-1:0] head_pc;
   logic             commit;
   logic             nw_pop;

   // Keep the PC alongside each entry for the retirement trace
   always_ff @(posedge clk) begin
      if (push) begin
         ent_pc[wptr] <= ms_to_ws_bus[PC_WD-1:0];
      end
   end

   assign head_pc = head_valid ? ent_pc[rptr] : '0;
   assign commit  = rf_we & rf_wr_ready;
   assign nw_pop  = pop & ~head_we;

   assign debug_wb_pc       = (commit | nw_pop) ? head_pc : '0;
   assign debug_wb_rf_we    = commit ? 4'hf : 4'h0;
   assign debug_wb_rf_wnum  = commit ? head_dest : '0;
   assign debug_wb_rf_wdata = commit ? head_data : '0;
`else
   logic unused_pc_bits;

   assign unused_pc_bits    = ^ms_to_ws_bus[PC_WD-1:0];

   assign debug_wb_pc       = '0;
   assign debug_wb_rf_we    = 4'h0;
   assign debug_wb_rf_wnum  = '0;
   assign debug_wb_rf_wdata = '0;
`endif

endmodule

// File: tb/tb_wb_retire_stage.sv
// tb_wb_retire_stage
//  Drives wb_retire_stage with directed sequences followed by random traffic
//  and compares every output each cycle against a queue-based model of an
//  in-order retire buffer.
module tb_wb_retire_stage;

   localparam int DATA_WD = 32;
   localparam int ADDR_WD = 5;
   localparam int PC_WD   = 32;
   localparam int DEPTH   = 4;
   localparam int CNT_WD  = $clog2(DEPTH + 1);
   localparam int BUS_WD  = 1 + ADDR_WD + DATA_WD + PC_WD;
   localparam int RF_WD   = 1 + ADDR_WD + DATA_WD;

   logic                clk = 1'b0;
   logic                reset;
   logic                ms_to_ws_valid;
   logic [BUS_WD-1:0]   ms_to_ws_bus;
   logic                ws_allowin;
   logic                flush;
   logic                rf_wr_ready;
   logic [RF_WD-1:0]    ws_to_rf_bus;
   logic                ws_to_ds_valid;
   logic [CNT_WD-1:0]   ws_pending_cnt;
   logic [ADDR_WD-1:0]  ds_rs1;
   logic [ADDR_WD-1:0]  ds_rs2;
   logic                ws_rs1_hit;
   logic                ws_rs2_hit;
   logic [DATA_WD-1:0]  ws_rs1_data;
   logic [DATA_WD-1:0]  ws_rs2_data;
   logic [PC_WD-1:0]    debug_wb_pc;
   logic [3:0]          debug_wb_rf_we;
   logic [ADDR_WD-1:0]  debug_wb_rf_wnum;
   logic [DATA_WD-1:0]  debug_wb_rf_wdata;

   always #5 clk = ~clk;

   wb_retire_stage #(
      .DATA_WD (DATA_WD),
      .ADDR_WD (ADDR_WD),
      .PC_WD   (PC_WD),
      .DEPTH   (DEPTH)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .ws_allowin        (ws_allowin),
      .flush             (flush),
      .rf_wr_ready       (rf_wr_ready),
      .ws_to_rf_bus      (ws_to_rf_bus),
      .ws_to_ds_valid    (ws_to_ds_valid),
      .ws_pending_cnt    (ws_pending_cnt),
      .ds_rs1            (ds_rs1),
      .ds_rs2            (ds_rs2),
      .ws_rs1_hit        (ws_rs1_hit),
      .ws_rs2_hit        (ws_rs2_hit),
      .ws_rs1_data       (ws_rs1_data),
      .ws_rs2_data       (ws_rs2_data),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_we    (debug_wb_rf_we),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata)
   );

   typedef struct packed {
      logic               we;
      logic [ADDR_WD-1:0] dest;
      logic [DATA_WD-1:0] data;
      logic [PC_WD-1:0]   pc;
   } entry_t;

   // Pending results, oldest at index 0
   entry_t model_q[$];

   int total = 0;
   int bad   = 0;

   // Count one comparison and report it when the values differ
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Youngest pending writer of register rs, if any
   function automatic void lookup(input logic [ADDR_WD-1:0] rs, output logic hit,
                                  output logic [DATA_WD-1:0] data);
      hit  = 1'b0;
      data = '0;
      if (rs != '0) begin
         for (int i = model_q.size() - 1; i >= 0; i--) begin
            if (model_q[i].we && model_q[i].dest == rs) begin
               hit  = 1'b1;
               data = model_q[i].data;
               break;
            end
         end
      end
   endfunction

   // One clock cycle: drive inputs, check all outputs, then advance the model
   task automatic applyStimulus(input logic rst, input logic valid, input logic gr_we,
                                input logic [ADDR_WD-1:0] dest, input logic [DATA_WD-1:0] data,
                                input logic [PC_WD-1:0] pc, input logic fl, input logic ready,
                                input logic [ADDR_WD-1:0] rs1, input logic [ADDR_WD-1:0] rs2);
      entry_t             h;
      entry_t             e;
      logic               has_head;
      logic               exp_allow;
      logic               exp_we;
      logic [RF_WD-1:0]   exp_bus;
      logic               exp_hit;
      logic [DATA_WD-1:0] exp_data;
      logic               commit;
      logic               nwpop;
      logic [PC_WD-1:0]   exp_pc;
      logic [3:0]         exp_rfwe;
      logic [ADDR_WD-1:0] exp_wnum;
      logic [DATA_WD-1:0] exp_wdata;

      @(negedge clk);
      reset          = rst;
      ms_to_ws_valid = valid;
      ms_to_ws_bus   = {gr_we, dest, data, pc};
      flush          = fl;
      rf_wr_ready    = ready;
      ds_rs1         = rs1;
      ds_rs2         = rs2;
      #1;

      h         = '0;
      has_head  = (model_q.size() != 0);
      if (has_head) h = model_q[0];
      exp_allow = (model_q.size() != DEPTH);
      exp_we    = has_head && h.we && !fl;
      exp_bus   = has_head ? {exp_we, h.dest, h.data} : '0;

      checkOutput("allowin", ws_allowin, exp_allow);
      checkOutput("ds_valid", ws_to_ds_valid, has_head);
      checkOutput("pending_cnt", ws_pending_cnt, model_q.size());
      checkOutput("rf_bus", ws_to_rf_bus, exp_bus);

      lookup(rs1, exp_hit, exp_data);
      checkOutput("rs1_hit", ws_rs1_hit, exp_hit);
      checkOutput("rs1_data", ws_rs1_data, exp_data);
      lookup(rs2, exp_hit, exp_data);
      checkOutput("rs2_hit", ws_rs2_hit, exp_hit);
      checkOutput("rs2_data", ws_rs2_data, exp_data);

`ifdef WB_TRACE_EN
      commit    = exp_we && ready;
      nwpop     = has_head && !h.we && !fl;
      exp_pc    = (commit || nwpop) ? h.pc : '0;
      exp_rfwe  = commit ? 4'hf : 4'h0;
      exp_wnum  = commit ? h.dest : '0;
      exp_wdata = commit ? h.data : '0;
`else
      commit    = 1'b0;
      nwpop     = 1'b0;
      exp_pc    = '0;
      exp_rfwe  = 4'h0;
      exp_wnum  = '0;
      exp_wdata = '0;
`endif
      checkOutput("dbg_pc", debug_wb_pc, exp_pc);
      checkOutput("dbg_we", debug_wb_rf_we, exp_rfwe);
      checkOutput("dbg_wnum", debug_wb_rf_wnum, exp_wnum);
      checkOutput("dbg_wdata", debug_wb_rf_wdata, exp_wdata);

      if (rst || fl) begin
         model_q.delete();
      end else begin
         if (has_head && (ready || !h.we)) void'(model_q.pop_front());
         if (valid && exp_allow) begin
            e.we   = gr_we;
            e.dest = dest;
            e.data = data;
            e.pc   = pc;
            model_q.push_back(e);
         end
      end
   endtask

   // Idle cycle with a given grant and bypass query
   task automatic idleCycle(input logic ready, input logic [ADDR_WD-1:0] rs1,
                            input logic [ADDR_WD-1:0] rs2);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, ready, rs1, rs2);
   endtask

   // Push one result with a given grant
   task automatic pushCycle(input logic gr_we, input logic [ADDR_WD-1:0] dest,
                            input logic [DATA_WD-1:0] data, input logic [PC_WD-1:0] pc,
                            input logic ready);
      applyStimulus(1'b0, 1'b1, gr_we, dest, data, pc, 1'b0, ready, dest, 5'd3);
   endtask

   // Directed scenarios followed by random traffic
   initial begin
      reset          = 1'b1;
      ms_to_ws_valid = 1'b0;
      ms_to_ws_bus   = '0;
      flush          = 1'b0;
      rf_wr_ready    = 1'b0;
      ds_rs1         = '0;
      ds_rs2         = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_q.delete();

      $display("[TB] reset state");
      idleCycle(1'b0, 5'd1, 5'd2);

      $display("[TB] single writer with grant");
      pushCycle(1'b1, 5'd5, 32'h1111, 32'h1c000000, 1'b1);
      idleCycle(1'b1, 5'd5, 5'd0);
      idleCycle(1'b1, 5'd5, 5'd0);

      $display("[TB] fill while stalled, refuse extra push, drain in order");
      for (int i = 1; i <= DEPTH + 1; i++)
         pushCycle(1'b1, 5'(i), 32'h20 + 32'(i), 32'h1c000100 + 32'(4 * i), 1'b0);
      for (int i = 0; i < DEPTH + 1; i++)
         idleCycle(1'b1, 5'd2, 5'd4);

      $display("[TB] bypass picks youngest producer");
      pushCycle(1'b1, 5'd3, 32'hA, 32'h1c000200, 1'b0);
      pushCycle(1'b1, 5'd3, 32'hB, 32'h1c000204, 1'b0);
      idleCycle(1'b0, 5'd3, 5'd0);
      idleCycle(1'b0, 5'd0, 5'd3);

      $display("[TB] flush a full buffer together with an incoming result");
      pushCycle(1'b1, 5'd6, 32'hC, 32'h1c000208, 1'b0);
      pushCycle(1'b0, 5'd7, 32'hD, 32'h1c00020c, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 5'd9, 32'hE, 32'h1c000210, 1'b1, 1'b1, 5'd9, 5'd3);
      idleCycle(1'b1, 5'd9, 5'd3);

      $display("[TB] non-writing entry retires without grant");
      pushCycle(1'b0, 5'd8, 32'h55, 32'h1c000300, 1'b0);
      idleCycle(1'b0, 5'd8, 5'd0);
      idleCycle(1'b0, 5'd8, 5'd0);

      $display("[TB] stream of writers with pointer wrap");
      for (int i = 0; i < 10; i++)
         pushCycle(1'b1, 5'(i + 10), 32'h1000 + 32'(i), 32'h1c000400 + 32'(4 * i), 1'b1);
      idleCycle(1'b1, 5'd19, 5'd0);
      idleCycle(1'b1, 5'd19, 5'd0);

      $display("[TB] random traffic");
      for (int n = 0; n < 600; n++) begin
         applyStimulus($urandom_range(0, 63) == 0,
                       $urandom_range(0, 3) != 0,
                       $urandom_range(0, 7) != 0,
                       5'($urandom_range(0, 7)),
                       $urandom,
                       $urandom,
                       $urandom_range(0, 15) == 0,
                       $urandom_range(0, 2) == 0,
                       5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
